axi_write_burst: RTL

AXI_WRITE_BURST -- requirements
Module: axi_write_burst

---
 rtl/axi_write_burst_if.sv | 43 ++++
 rtl/axi_write_burst.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/axi_write_burst_if.sv
// rtl/axi_write_burst_if.sv - AXI4 write-channel bundle for axi_write_burst
//
// Purpose: groups the AW, W and B channel signals of one AXI4 write master.
// Modports:
//   master - the burst engine (drives AW/W payload and valids, B ready)
//   slave  - the interconnect/memory side (drives readies and B response)
interface axi_write_burst_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0]   m_axi_awaddr;
  logic [2:0]          m_axi_awprot;
  logic [7:0]          m_axi_awlen;
  logic [2:0]          m_axi_awsize;
  logic [1:0]          m_axi_awburst;
  logic                m_axi_awlock;
  logic                m_axi_awvalid;
  logic                m_axi_awready;
  logic [DATA_W-1:0]   m_axi_wdata;
  logic [DATA_W/8-1:0] m_axi_wstrb;
  logic                m_axi_wlast;
  logic                m_axi_wvalid;
  logic                m_axi_wready;
  logic [1:0]          m_axi_bresp;
  logic                m_axi_bvalid;
  logic                m_axi_bready;

  modport master (
    output m_axi_awaddr, m_axi_awprot, m_axi_awlen, m_axi_awsize,
           m_axi_awburst, m_axi_awlock, m_axi_awvalid,
           m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
           m_axi_bready,
    input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
  );

  modport slave (
    input  m_axi_awaddr, m_axi_awprot, m_axi_awlen, m_axi_awsize,
           m_axi_awburst, m_axi_awlock, m_axi_awvalid,
           m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
           m_axi_bready,
    output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
  );
endinterface

// File: rtl/axi_write_burst.sv
// rtl/axi_write_burst.sv - single INCR AXI4 write burst sourced from a BRAM
//
// Purpose: on run, issues one INCR burst of byte_length/8 beats starting at
// start_addr, streaming BRAM words 0..beats-1 through a 2-entry prefetch FIFO.
// Ports:
//   m_axi_aclk, m_axi_areset   - clock, synchronous active-high reset
//   m_axi (master modport)     - AXI4 AW/W/B channels
//   run, start_addr, byte_length - start request, sampled only in IDLE
//   bram_read_*                - BRAM read port, data returns one cycle later
//   busy, done, error          - status: not idle, completion pulse, bresp[1]
module axi_write_burst #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 64
) (
  input  logic                          m_axi_aclk,
  input  logic                          m_axi_areset,
  axi_write_burst_if.master             m_axi,
  input  logic                          run,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] start_addr,
  input  logic [9:0]                    byte_length,
  output logic                          bram_read_enable,
  output logic [9:0]                    bram_read_index,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] bram_read_data,
  output logic                          busy,
  output logic                          done,
  output logic                          error
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   awaddr_q, awaddr_d;
  logic [7:0]      awlen_q, awlen_d;
  logic            awvalid_q, awvalid_d;
  logic [7:0]      beats_q, beats_d;
  logic [7:0]      fetch_q, fetch_d;      // BRAM words requested this burst
  logic [7:0]      beat_cnt_q, beat_cnt_d; // W beats retired this burst
  logic            pend_q, pend_d;        // a BRAM read returns this cycle
  logic [DW-1:0]   mem_q [2];
  logic [DW-1:0]   mem_d [2];
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic            wvalid, wlast, pop, rd_en;
  logic [7:0]      beats_in;
  logic [2:0]      occ_after;

  always_comb begin
    state_d    = state_q;
    awaddr_d   = awaddr_q;
    awlen_d    = awlen_q;
    awvalid_d  = awvalid_q;
    beats_d    = beats_q;
    fetch_d    = fetch_q;
    beat_cnt_d = beat_cnt_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    done_d     = 1'b0;
    error_d    = error_q;

    beats_in = 8'(byte_length >> 3);
    wvalid   = (state_q == S_DATA) && (count_q != 2'd0);
    wlast    = wvalid && (beat_cnt_q == awlen_q);
    pop      = wvalid && m_axi.m_axi_wready;

    // Occupancy counts the beat leaving this cycle, otherwise the FIFO
    // pointer chase would only sustain one beat every other cycle.
    occ_after = {1'b0, count_q} + {2'b00, pend_q} - {2'b00, pop};
    rd_en = ((state_q == S_ADDR) || (state_q == S_DATA)) &&
            (fetch_q < beats_q) && (occ_after < 3'd2);
    pend_d = rd_en;
    if (rd_en) fetch_d = fetch_q + 8'd1;

    if (pend_q) begin
      mem_d[wr_ptr_q] = bram_read_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d   = ~rd_ptr_q;
      beat_cnt_d = beat_cnt_q + 8'd1;
    end
    count_d = count_q + {1'b0, pend_q} - {1'b0, pop};

    case (state_q)
      S_IDLE: begin
        if (run && (beats_in != 8'd0)) begin
          state_d    = S_ADDR;
          awaddr_d   = start_addr & ~AW'(7);
          awlen_d    = beats_in - 8'd1;
          awvalid_d  = 1'b1;
          beats_d    = beats_in;
          fetch_d    = 8'd0;
          beat_cnt_d = 8'd0;
          error_d    = 1'b0;
        end
      end
      S_ADDR: begin
        if (awvalid_q && m_axi.m_axi_awready) begin
          awvalid_d = 1'b0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (pop && wlast) state_d = S_RESP;
      end
      S_RESP: begin
        if (m_axi.m_axi_bvalid) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          error_d = |(m_axi.m_axi_bresp & 2'b10);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state_q    <= S_IDLE;
      awaddr_q   <= '0;
      awlen_q    <= '0;
      awvalid_q  <= 1'b0;
      beats_q    <= '0;
      fetch_q    <= '0;
      beat_cnt_q <= '0;
      pend_q     <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      awaddr_q   <= awaddr_d;
      awlen_q    <= awlen_d;
      awvalid_q  <= awvalid_d;
      beats_q    <= beats_d;
      fetch_q    <= fetch_d;
      beat_cnt_q <= beat_cnt_d;
      pend_q     <= pend_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign m_axi.m_axi_awaddr  = awaddr_q;
  assign m_axi.m_axi_awprot  = 3'b000;
  assign m_axi.m_axi_awlen   = awlen_q;
  assign m_axi.m_axi_awsize  = 3'b011;
  assign m_axi.m_axi_awburst = 2'b01;
  assign m_axi.m_axi_awlock  = 1'b0;
  assign m_axi.m_axi_awvalid = awvalid_q;
  assign m_axi.m_axi_wdata   = mem_q[rd_ptr_q];
  assign m_axi.m_axi_wstrb   = '1;
  assign m_axi.m_axi_wlast   = wlast;
  assign m_axi.m_axi_wvalid  = wvalid;
  assign m_axi.m_axi_bready  = (state_q == S_RESP);

  assign bram_read_enable = rd_en;
  assign bram_read_index  = {2'b00, fetch_q};
  assign busy             = (state_q != S_IDLE);
  assign done             = done_q;
  assign error            = error_q;
endmodule
